// File: rtl/sseg_pkg.sv
// sseg_pkg: shared widths, FSM states and the active-low gfedcba hex segment table
package sseg_pkg;
  localparam int SSEG_PW = 7;
  localparam int SSEG_AW = 4;
  typedef enum logic {IDLE, SEARCH} state_t;
  localparam logic [SSEG_PW-1:0] SEG_TABLE [2**SSEG_AW] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
endpackage

// File: rtl/sseg_pattern_decoder.sv
// sseg_pattern_decoder: sequential reverse lookup of a segment pattern to its hex digit; SSEG_PATTERN_DECODER_CACHE_EN adds a last-hit cache
module sseg_pattern_decoder
  import sseg_pkg::*;
#(
  parameter int PW = SSEG_PW,
  parameter int AW = SSEG_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [PW-1:0] seg_in,
  output logic          ready,
  output logic          done,
  output logic          hit,
  output logic [AW-1:0] digit
);
  state_t        state;
  logic [PW-1:0] pat_reg;
  logic [AW-1:0] idx;
  logic [AW-1:0] start_idx;
  logic          match;
  assign ready = (state == IDLE);
  assign match = (pat_reg == SEG_TABLE[idx]);
`ifdef SSEG_PATTERN_DECODER_CACHE_EN
  logic          c_valid;
  logic [PW-1:0] c_pat;
  logic [AW-1:0] c_dig;
  // a cached hit starts the search on its own entry, so it matches on the first compare
  assign start_idx = (c_valid && seg_in == c_pat) ? c_dig : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      c_valid <= 1'b0;
      c_pat   <= '0;
      c_dig   <= '0;
    end else if (state == SEARCH && match) begin
      c_valid <= 1'b1;
      c_pat   <= pat_reg;
      c_dig   <= idx;
    end
`else
  assign start_idx = '0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      pat_reg <= '0;
      idx     <= '0;
      done    <= 1'b0;
      hit     <= 1'b0;
      digit   <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (req) begin
          pat_reg <= seg_in;
          idx     <= start_idx;
          state   <= SEARCH;
        end
      end else if (match) begin
        state <= IDLE;
        digit <= idx;
        hit   <= 1'b1;
        done  <= 1'b1;
      end else if (&idx) begin
        state <= IDLE;
        digit <= '0;
        hit   <= 1'b0;
        done  <= 1'b1;
      end else begin
        idx <= idx + 1'b1;
      end
    end
endmodule
